serial_word_receiver: RTL and testbench

//  Parametrised serial-to-parallel front end for the FIR filter datapath. Collects

---
 rtl/serial_word_receiver.sv | 135 +++++++++++++
 tb/tb_serial_word_receiver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word capture for the FIR input: LANES bits per beat, framing
// check on the last flag, completed words buffered in a small FIFO with valid/ready.
module serial_word_receiver #(
    parameter int DATA_WIDTH = 24,
    parameter int LANES      = 1,
    parameter int MSB_FIRST  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_en,
    input  logic [LANES-1:0]              i_din,
    input  logic                          i_din_valid,
    input  logic                          i_din_last,
    output logic                          o_ready,
    output logic [DATA_WIDTH-1:0]         o_word,
    output logic                          o_word_valid,
    input  logic                          i_word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_frame_err
);
    localparam int BEATS = DATA_WIDTH / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int NW    = PW + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RECV   = 2'd1;
    localparam logic [1:0] S_RESYNC = 2'd2;

    logic [1:0]            state, state_nxt;
    logic [CW-1:0]         beat_cnt, beat_cnt_nxt;
    logic [DATA_WIDTH-1:0] asm_word, asm_nxt;
    logic                  push, err_nxt, accept, pop, final_beat, run;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [NW-1:0]         count;

    // run holds o_ready low through reset and the first edge after release
    assign o_ready      = run & i_en & (count < NW'(FIFO_DEPTH));
    assign accept       = i_din_valid & o_ready;
    assign pop          = o_word_valid & i_word_ready;
    assign final_beat   = (beat_cnt == CW'(BEATS - 1));
    assign o_word       = mem[rd_ptr];
    assign o_word_valid = (count != '0);
    assign o_fifo_count = count;

    // Merge the current beat into the partial word; a new word starts from zero
    always_comb begin
        asm_nxt = (state == S_IDLE) ? '0 : asm_word;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_cnt == CW'(b)) begin
                if (MSB_FIRST != 0)
                    asm_nxt[DATA_WIDTH - (b + 1) * LANES +: LANES] = i_din;
                else
                    asm_nxt[b * LANES +: LANES] = i_din;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        push         = 1'b0;
        err_nxt      = 1'b0;
        if (accept) begin
            case (state)
                S_IDLE, S_RECV: begin
                    if (final_beat) begin
                        beat_cnt_nxt = '0;
                        if (i_din_last) begin
                            push      = 1'b1;
                            state_nxt = S_IDLE;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = S_RESYNC;
                        end
                    end else if (i_din_last) begin
                        err_nxt      = 1'b1;
                        beat_cnt_nxt = '0;
                        state_nxt    = S_IDLE;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 1'b1;
                        state_nxt    = S_RECV;
                    end
                end
                S_RESYNC: begin
                    if (i_din_last) state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt    = S_IDLE;
                    beat_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            beat_cnt    <= '0;
            asm_word    <= '0;
            o_frame_err <= 1'b0;
            run         <= 1'b0;
        end else begin
            run         <= 1'b1;
            state       <= state_nxt;
            beat_cnt    <= beat_cnt_nxt;
            o_frame_err <= err_nxt;
            if (accept) asm_word <= asm_nxt;
        end
    end

    // Word FIFO; pointers wrap naturally since the depth is a power of two
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= asm_nxt;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_word_receiver.sv
// Randomized bench for serial_word_receiver: a frame-level reference model predicts
// FIFO contents, ready, count and framing-error pulses every cycle.
module tb_serial_word_receiver;
    localparam int DW = 24;
    localparam int L  = 4;
    localparam int MF = 1;
    localparam int D  = 4;
    localparam int BEATS = DW / L;

    logic          tb_clk = 1'b0;
    logic          rst_n;
    logic          en, din_valid, din_last, ready, word_valid, word_ready, frame_err;
    logic [L-1:0]  din;
    logic [DW-1:0] word;
    logic [2:0]    fifo_count;

    logic          d1_en, d1_valid, d1_last, d1_ready, d1_wvalid, d1_wready, d1_err;
    logic [0:0]    d1_din;
    logic [DW-1:0] d1_word;
    logic [2:0]    d1_count;

    always #5 tb_clk = ~tb_clk;

    serial_word_receiver #(.DATA_WIDTH(DW), .LANES(L), .MSB_FIRST(MF), .FIFO_DEPTH(D)) dut (
        .i_clk(tb_clk), .i_rst_n(rst_n), .i_en(en), .i_din(din), .i_din_valid(din_valid),
        .i_din_last(din_last), .o_ready(ready), .o_word(word), .o_word_valid(word_valid),
        .i_word_ready(word_ready), .o_fifo_count(fifo_count), .o_frame_err(frame_err));

    serial_word_receiver #(.DATA_WIDTH(DW), .LANES(1), .MSB_FIRST(0), .FIFO_DEPTH(D)) dut1 (
        .i_clk(tb_clk), .i_rst_n(rst_n), .i_en(d1_en), .i_din(d1_din), .i_din_valid(d1_valid),
        .i_din_last(d1_last), .o_ready(d1_ready), .o_word(d1_word), .o_word_valid(d1_wvalid),
        .i_word_ready(d1_wready), .o_fifo_count(d1_count), .o_frame_err(d1_err));

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] q[$];
    int            cur[$];
    bit            resync, exp_err;
    int            wr_mode;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] assemble();
        logic [31:0] w = 0;
        for (int k = 0; k < BEATS; k++)
            w = w | (32'(cur[k]) << (MF != 0 ? (BEATS - 1 - k) * L : k * L));
        return w[DW-1:0];
    endfunction

    task automatic model_beat(input int d, input bit l);
        if (resync) begin
            if (l) resync = 0;
            return;
        end
        cur.push_back(d);
        if (cur.size() == BEATS) begin
            if (l) q.push_back(assemble());
            else begin exp_err = 1; resync = 1; end
            cur.delete();
        end else if (l) begin
            exp_err = 1;
            cur.delete();
        end
    endtask

    // One clock: drive, compare against the model, advance the model, step the edge
    task automatic cyc(input bit v, input int d, input bit l, input bit e, output bit acc);
        bit rdy, wr, pop;
        wr = (wr_mode == 1) || (wr_mode == 2 && $urandom_range(0, 1) == 1);
        din_valid = v; din = L'(d); din_last = l; en = e; word_ready = wr;
        #1;
        rdy = e && q.size() < D;
        chk("ready", 32'(ready), 32'(rdy));
        chk("count", 32'(fifo_count), 32'(q.size()));
        chk("word_valid", 32'(word_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("word", 32'(word), 32'(q[0]));
        chk("frame_err", 32'(frame_err), 32'(exp_err));
        pop = wr && q.size() != 0;
        acc = v && rdy;
        exp_err = 0;
        if (pop) void'(q.pop_front());
        if (acc) model_beat(d, l);
        @(posedge tb_clk); #1;
    endtask

    task automatic send_beat(input int d, input bit l);
        bit acc;
        int n = 0;
        if ($urandom_range(0, 3) == 0) cyc(0, 0, 0, 1, acc);
        do begin
            cyc(1, d, l, $urandom_range(0, 7) != 0, acc);
            n++;
        end while (!acc && n < 300);
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int last_at);
        for (int k = 0; k < BEATS; k++)
            send_beat(int'((w >> (MF != 0 ? (BEATS - 1 - k) * L : k * L)) & 24'hF), k == last_at);
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        wr_mode = 1;
        while (q.size() != 0 && n < 50) begin cyc(0, 0, 0, 1, acc); n++; end
        cyc(0, 0, 0, 1, acc);
        if (q.size() != 0) chk("drain_timeout", 0, 1);
    endtask

    task automatic model_reset();
        q.delete(); cur.delete(); resync = 0; exp_err = 0;
    endtask

    initial begin
        bit acc;
        logic [DW-1:0] w1;
        rst_n = 0; en = 1; din = '0; din_valid = 0; din_last = 0; word_ready = 0;
        d1_en = 1; d1_din = '0; d1_valid = 0; d1_last = 0; d1_wready = 0;
        wr_mode = 0;
        model_reset();
        repeat (2) @(posedge tb_clk);
        #1;
        chk("rst_ready", 32'(ready), 0);
        chk("rst_word_valid", 32'(word_valid), 0);
        chk("rst_word", 32'(word), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_d1_ready", 32'(d1_ready), 0);
        #2 rst_n = 1;
        @(posedge tb_clk); #1;

        // 1-lane LSB-first capture on the second instance
        w1 = 24'h5A3C81;
        for (int k = 0; k < DW; k++) begin
            d1_valid = 1; d1_din = w1[k]; d1_last = (k == DW - 1);
            #1 chk("t1_d1_ready", 32'(d1_ready), 1);
            @(posedge tb_clk); #1;
            if (k == DW - 2) chk("t1_not_yet_valid", 32'(d1_wvalid), 0);
        end
        d1_valid = 0; d1_last = 0;
        chk("t1_valid", 32'(d1_wvalid), 1);
        chk("t1_word", 32'(d1_word), 32'h5A3C81);
        chk("t1_count", 32'(d1_count), 1);
        chk("t1_no_err", 32'(d1_err), 0);

        // 4-lane MSB-first word
        wr_mode = 0;
        for (int k = 0; k < BEATS; k++) send_beat(k + 1, k == BEATS - 1);
        cyc(0, 0, 0, 1, acc);
        chk("t2_word", 32'(word), 32'h123456);
        drain();

        // Fill past depth with no consumer, then release
        wr_mode = 0;
        for (int i = 0; i < 4; i++) send_word(DW'(32'h100000 * (i + 1) + 32'(i + 1)), BEATS - 1);
        repeat (3) cyc(0, 0, 0, 1, acc);
        chk("t3_full_count", 32'(fifo_count), 4);
        wr_mode = 2;
        send_word(24'h500005, BEATS - 1);
        drain();

        // Early last, then a good word
        wr_mode = 2;
        send_word(DW'($urandom), 2);
        send_word(24'hA5A5A5, BEATS - 1);
        drain();

        // Missing last, resync on third junk beat, then a good word
        send_word(DW'($urandom), -1);
        send_beat(int'($urandom_range(0, 15)), 0);
        send_beat(int'($urandom_range(0, 15)), 0);
        send_beat(int'($urandom_range(0, 15)), 1);
        send_word(24'h000001, BEATS - 1);
        drain();

        // Random mix of good and malformed frames
        for (int i = 0; i < 40; i++) begin
            int r = int'($urandom_range(0, 9));
            wr_mode = int'($urandom_range(0, 2));
            if (r < 7) send_word(DW'($urandom), BEATS - 1);
            else if (r < 9) send_word(DW'($urandom), int'($urandom_range(0, BEATS - 2)));
            else send_word(DW'($urandom), -1);
            if (resync) send_beat(int'($urandom_range(0, 15)), 1);
            if (q.size() == D) drain();
        end
        drain();

        // Async reset mid-word with two words queued
        wr_mode = 0;
        send_word(24'hC0FFEE, BEATS - 1);
        send_word(24'h0BEEF0, BEATS - 1);
        send_beat(7, 0);
        send_beat(8, 0);
        en = 1; din_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("t6_word_valid", 32'(word_valid), 0);
        chk("t6_count", 32'(fifo_count), 0);
        chk("t6_word", 32'(word), 0);
        chk("t6_ready", 32'(ready), 0);
        chk("t6_d1_count", 32'(d1_count), 0);
        model_reset();
        @(negedge tb_clk) rst_n = 1;
        @(posedge tb_clk); #1;
        wr_mode = 2;
        send_word(24'h654321, BEATS - 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
